// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
//
// Coprocessor-0 exception controller sitting at the consuming end of the
// MEM-stage exception flags. It arbitrates synchronous exceptions and
// level-sensitive hardware interrupts. It also holds the SR, Cause, EPC and
// PRId registers. It raises req in the same cycle so that the whole pipeline
// can flush and the MEM-stage PC register can load the handler vector.
// It also serves mfc0/mtc0 and supplies EPC for eret.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (0 = reset)
//   mem_pc     PC of the instruction in MEM; 0 marks a bubble
//   mem_bd     MEM instruction sits in a branch delay slot
//   adel_if    fetch address error
//   adel_ld    load address error
//   ades       store address error
//   ov         arithmetic overflow
//   ri         reserved instruction
//   syscall    syscall instruction
//   hw_int     external interrupt lines, level-sensitive
//   cp0_we     mtc0 in MEM
//   cp0_addr   CP0 register number (rd field)
//   cp0_wdata  mtc0 write data
//   eret       eret in MEM
//   req        take exception/interrupt this cycle (combinational)
//   cp0_rdata  mfc0 read data (combinational, pre-edge values)
//   epc_out    EPC for the eret redirect, with mtc0 bypass
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID = 32'h2022_1106
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic        adel_if,
  input  logic        adel_ld,
  input  logic        ades,
  input  logic        ov,
  input  logic        ri,
  input  logic        syscall,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret,
  output logic        req,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR fields; all other SR bits are hard-wired to zero
  logic [5:0]  r_srIm;
  logic        r_srExl;
  logic        r_srIe;
  // Cause fields
  logic        r_causeBd;
  logic [5:0]  r_causeIp;
  logic [4:0]  r_excCode;
  // Exception PC
  logic [31:0] r_epc;

  logic        w_intReq;
  logic        w_excReq;
  logic        w_anyExc;
  logic [4:0]  w_excCode;
  logic [31:0] w_epcNext;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_wrSr;
  logic        w_wrEpc;

  // Interrupts are never taken on a bubble because it has no PC to
  // return to. Exceptions always come from a real instruction. EXL masks
  // both, so handlers never nest.
  assign w_anyExc = adel_if | adel_ld | ades | ov | ri | syscall;
  assign w_intReq = (|(hw_int & r_srIm)) & r_srIe & ~r_srExl & (mem_pc != 32'd0);
  assign w_excReq = w_anyExc & ~r_srExl;
  assign req      = w_intReq | w_excReq;

  // Fetch-side errors precede anything the instruction itself could raise.
  // Data-side address errors come last because the access never happens.
  always_comb begin
    w_excCode = EXC_INT;
    if (w_intReq)     w_excCode = EXC_INT;
    else if (adel_if) w_excCode = EXC_ADEL;
    else if (ri)      w_excCode = EXC_RI;
    else if (ov)      w_excCode = EXC_OV;
    else if (syscall) w_excCode = EXC_SYS;
    else if (adel_ld) w_excCode = EXC_ADEL;
    else if (ades)    w_excCode = EXC_ADES;
  end

  // A delay-slot instruction restarts at its branch, one word earlier.
  // Wrap-around is intentional; no alignment correction is applied.
  assign w_epcNext = mem_bd ? (mem_pc - 32'd4) : mem_pc;

  // A taken exception squashes any mtc0 in MEM.
  assign w_wrSr  = cp0_we & (cp0_addr == ADDR_SR)  & ~req;
  assign w_wrEpc = cp0_we & (cp0_addr == ADDR_EPC) & ~req;

  assign w_sr    = {16'd0, r_srIm, 8'd0, r_srExl, r_srIe};
  assign w_cause = {r_causeBd, 15'd0, r_causeIp, 3'd0, r_excCode, 2'd0};

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = w_sr;
      ADDR_CAUSE: cp0_rdata = w_cause;
      ADDR_EPC:   cp0_rdata = r_epc;
      ADDR_PRID:  cp0_rdata = PRID;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  // This bypass covers an mtc0 EPC followed by eret in the same cycle.
  // The handler can then redirect to the freshly written value.
  assign epc_out = w_wrEpc ? cp0_wdata : r_epc;

  // The interrupt-pending bits follow the lines every cycle. A taken
  // exception takes precedence over mtc0 and eret. When eret and an mtc0 to
  // SR coincide, the written bits land first and eret then clears EXL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_srIm    <= 6'd0;
      r_srExl   <= 1'b0;
      r_srIe    <= 1'b0;
      r_causeBd <= 1'b0;
      r_causeIp <= 6'd0;
      r_excCode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_causeIp <= hw_int;
      if (req) begin
        r_srExl   <= 1'b1;
        r_causeBd <= mem_bd;
        r_excCode <= w_excCode;
        r_epc     <= w_epcNext;
      end else begin
        if (w_wrSr) begin
          r_srIm  <= cp0_wdata[15:10];
          r_srExl <= cp0_wdata[1];
          r_srIe  <= cp0_wdata[0];
        end
        if (w_wrEpc) begin
          r_epc <= cp0_wdata;
        end
        if (eret) begin
          r_srExl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl
//
// Directed bench for cp0_exc_ctrl. A table of per-cycle vectors lists the
// inputs for each cycle. It also lists the expected combinational outputs
// (req, cp0_rdata at the given address, and epc_out) before the clock edge.
// A hand-written sequence covers the mtc0-during-exception case, a
// mid-cycle reset, and the EPC wrap-around.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  // Exception flag bit positions: {adel_if, adel_ld, ades, ov, ri, syscall}
  localparam logic [5:0] X_NONE  = 6'b000000;
  localparam logic [5:0] X_ADIF  = 6'b100000;
  localparam logic [5:0] X_ADLD  = 6'b010000;
  localparam logic [5:0] X_ADES  = 6'b001000;
  localparam logic [5:0] X_OV    = 6'b000100;
  localparam logic [5:0] X_RI    = 6'b000010;
  localparam logic [5:0] X_SYS   = 6'b000001;

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic [5:0]  exc;
    logic [5:0]  hw;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic        expReq;
    logic [31:0] expRdata;
    logic [31:0] expEpc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic        adel_if, adel_ld, ades, ov, ri, syscall;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret;
  logic        req;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;

  int nChecks = 0;
  int nFails  = 0;
  vec_t vecs[$];

  cp0_exc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .mem_pc    (mem_pc),
    .mem_bd    (mem_bd),
    .adel_if   (adel_if),
    .adel_ld   (adel_ld),
    .ades      (ades),
    .ov        (ov),
    .ri        (ri),
    .syscall   (syscall),
    .hw_int    (hw_int),
    .cp0_we    (cp0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .eret      (eret),
    .req       (req),
    .cp0_rdata (cp0_rdata),
    .epc_out   (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] pc, input logic bd,
                              input logic [5:0] exc, input logic [5:0] hw,
                              input logic we, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic er,
                              input logic eReq, input logic [31:0] eRd,
                              input logic [31:0] eEpc);
    vec_t v;
    v.pc = pc; v.bd = bd; v.exc = exc; v.hw = hw; v.we = we;
    v.addr = addr; v.wdata = wdata; v.eret = er;
    v.expReq = eReq; v.expRdata = eRd; v.expEpc = eEpc;
    return v;
  endfunction

  // Drives one cycle's worth of inputs; called just after a falling edge
  task automatic applyStimulus(input vec_t v);
    mem_pc    = v.pc;
    mem_bd    = v.bd;
    {adel_if, adel_ld, ades, ov, ri, syscall} = v.exc;
    hw_int    = v.hw;
    cp0_we    = v.we;
    cp0_addr  = v.addr;
    cp0_wdata = v.wdata;
    eret      = v.eret;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(mk(32'd0, 1'b0, X_NONE, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0,
                     1'b0, 32'd0, 32'd0));
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    //               pc            bd    exc           hw      we    addr   wdata          eret  req   rdata          epc_out
    // reset state
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd12, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd13, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd14, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd15, 32'h0,         1'b0, 1'b0, 32'h2022_1106, 32'h0));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd20, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0));
    // overflow at 0x3010
    vecs.push_back(mk(32'h3010,    1'b0, X_OV,         6'd0,  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 32'h0,         32'h0));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd14, 32'h0,         1'b0, 1'b0, 32'h3010,      32'h3010));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd13, 32'h0,         1'b0, 1'b0, 32'h0000_0030, 32'h3010));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd12, 32'h0,         1'b0, 1'b0, 32'h0000_0002, 32'h3010));
    // masked while EXL=1
    vecs.push_back(mk(32'h3020,    1'b0, X_OV,         6'd0,  1'b0, 5'd12, 32'h0,         1'b0, 1'b0, 32'h0000_0002, 32'h3010));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd12, 32'h0,         1'b1, 1'b0, 32'h0000_0002, 32'h3010));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd12, 32'h0,         1'b0, 1'b0, 32'h0,         32'h3010));
    // delay slot, adel_if beats ri
    vecs.push_back(mk(32'h3024,    1'b1, X_ADIF|X_RI,  6'd0,  1'b0, 5'd13, 32'h0,         1'b0, 1'b1, 32'h0000_0030, 32'h3010));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd13, 32'h0,         1'b0, 1'b0, 32'h8000_0010, 32'h3020));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd14, 32'h0,         1'b0, 1'b0, 32'h3020,      32'h3020));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd12, 32'h0,         1'b1, 1'b0, 32'h0000_0002, 32'h3020));
    // interrupts: enable IM0 and IE, bubble blocks, real PC takes it
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b1, 5'd12, 32'h0000_0401, 1'b0, 1'b0, 32'h0,         32'h3020));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd12, 32'h0,         1'b0, 1'b0, 32'h0000_0401, 32'h3020));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd1,  1'b0, 5'd13, 32'h0,         1'b0, 1'b0, 32'h8000_0010, 32'h3020));
    vecs.push_back(mk(32'h3000,    1'b0, X_NONE,       6'd1,  1'b0, 5'd13, 32'h0,         1'b0, 1'b1, 32'h8000_0410, 32'h3020));
    vecs.push_back(mk(32'h3004,    1'b0, X_OV,         6'd1,  1'b0, 5'd13, 32'h0,         1'b0, 1'b0, 32'h0000_0400, 32'h3000));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd12, 32'h0,         1'b0, 1'b0, 32'h0000_0403, 32'h3000));
    // mtc0 EPC + eret same cycle: bypass
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b1, 5'd14, 32'h3100,      1'b1, 1'b0, 32'h3000,      32'h3100));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd12, 32'h0,         1'b0, 1'b0, 32'h0000_0401, 32'h3100));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd14, 32'h0,         1'b0, 1'b0, 32'h3100,      32'h3100));
    // syscall beats adel_ld and ades
    vecs.push_back(mk(32'h3040,    1'b0, X_SYS|X_ADLD|X_ADES, 6'd0, 1'b0, 5'd13, 32'h0,  1'b0, 1'b1, 32'h0,         32'h3100));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd13, 32'h0,         1'b0, 1'b0, 32'h0000_0020, 32'h3040));
    // eret with mtc0 SR all-ones: masked write, EXL forced clear
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b1, 5'd12, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0403, 32'h3040));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd12, 32'h0,         1'b0, 1'b0, 32'h0000_FC01, 32'h3040));
    // store address error alone
    vecs.push_back(mk(32'h3050,    1'b0, X_ADES,       6'd0,  1'b0, 5'd13, 32'h0,         1'b0, 1'b1, 32'h0000_0020, 32'h3040));
    vecs.push_back(mk(32'h0,       1'b0, X_NONE,       6'd0,  1'b0, 5'd13, 32'h0,         1'b0, 1'b0, 32'h0000_0014, 32'h3050));

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.req", i),   {31'd0, req}, {31'd0, vecs[i].expReq});
      checkOutput($sformatf("v%0d.rdata", i), cp0_rdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d.epc", i),   epc_out, vecs[i].expEpc);
    end

    // Leave EXL, then overflow alongside an mtc0 to SR clearing everything
    @(negedge clk);
    applyStimulus(mk(32'h0, 1'b0, X_NONE, 6'd0, 1'b0, 5'd12, 32'h0, 1'b1,
                     1'b0, 32'h0, 32'h0));
    @(negedge clk);
    applyStimulus(mk(32'h3060, 1'b0, X_OV, 6'd0, 1'b1, 5'd12, 32'h0, 1'b0,
                     1'b0, 32'h0, 32'h0));
    #1;
    checkOutput("ovWithMtc0.req", {31'd0, req}, 32'd1);
    checkOutput("ovWithMtc0.rdSr", cp0_rdata, 32'h0000_FC01);
    checkOutput("ovWithMtc0.epc", epc_out, 32'h3050);
    @(negedge clk);
    idle();
    cp0_addr = 5'd12;
    #1;
    checkOutput("afterOv.sr", cp0_rdata, 32'h0000_FC03);
    cp0_addr = 5'd14;
    #1;
    checkOutput("afterOv.epc", cp0_rdata, 32'h3060);

    // Reset asserted mid-cycle clears everything without waiting for a clock
    #2;
    reset = 1'b0;
    cp0_addr = 5'd12;
    #1;
    checkOutput("midReset.sr", cp0_rdata, 32'h0);
    cp0_addr = 5'd14;
    #1;
    checkOutput("midReset.epc", cp0_rdata, 32'h0);
    checkOutput("midReset.epcOut", epc_out, 32'h0);
    cp0_addr = 5'd15;
    #1;
    checkOutput("midReset.prid", cp0_rdata, 32'h2022_1106);
    checkOutput("midReset.req", {31'd0, req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Delay slot at PC 2 wraps below zero
    @(negedge clk);
    applyStimulus(mk(32'h2, 1'b1, X_RI, 6'd0, 1'b0, 5'd13, 32'h0, 1'b0,
                     1'b0, 32'h0, 32'h0));
    #1;
    checkOutput("wrap.req", {31'd0, req}, 32'd1);
    checkOutput("wrap.rdCause", cp0_rdata, 32'h0);
    @(negedge clk);
    idle();
    cp0_addr = 5'd14;
    #1;
    checkOutput("wrap.epc", cp0_rdata, 32'hFFFF_FFFE);
    cp0_addr = 5'd13;
    #1;
    checkOutput("wrap.cause", cp0_rdata, 32'h8000_0028);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
